dibit_serializer: RTL and testbench

- Upstream feeder for the mod-3 dibit counter FSM.
- Accepts parallel words over a valid/ready handshake and emits them as 2-bit symbols on data_out, one per clock, MSB dibit first.
- Drives 2'b00 whenever it has nothing to send, because 2'b00 leaves the downstream counter state unchanged.
- A one-word holding register allows zero-gap back-to-back streaming.

---
 rtl/dibit_serializer.sv | 117 +++++++++++
 tb/tb_dibit_serializer.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/dibit_serializer.sv
// Serializes WIDTH-bit words into 2-bit symbols, MSB dibit first, with a
// one-word holding register so consecutive words stream with no idle gap.
module dibit_serializer #(
    parameter int WIDTH = 8
) (
    input  logic             clock,
    input  logic             reset,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             abort,
    output logic [1:0]       data_out,
    output logic             sow,
    output logic             eow,
    output logic             busy,
    output logic             state_dbg
);

    localparam int NSYM = WIDTH / 2;
    localparam int CW = (NSYM > 1) ? $clog2(NSYM) : 1;
    localparam logic [CW-1:0] LAST = CW'(NSYM - 1);

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    state_t           state;
    logic [WIDTH-1:0] shifter;
    logic [WIDTH-1:0] hold;
    logic [WIDTH-1:0] shifted;
    logic [WIDTH-1:0] load_word;
    logic [CW-1:0]    cnt;
    logic             hold_full;
    logic             accept;
    logic             last;
    logic             load;

    // Valid/ready: a word transfers at a rising edge where in_valid && in_ready;
    // in_ready depends only on hold_full, never on in_valid.
    assign in_ready  = !hold_full;
    assign accept    = in_valid && in_ready;
    assign last      = (cnt == LAST);
    assign shifted   = shifter << 2;
    assign state_dbg = state;

    // A new word enters the shifter from IDLE, or on the last dibit of the
    // current word; the held word takes precedence over a fresh input.
    always_comb begin
        load      = 1'b0;
        load_word = in_data;
        if (state == IDLE) begin
            load = accept;
        end else if (last) begin
            if (hold_full) begin
                load      = 1'b1;
                load_word = hold;
            end else begin
                load = accept;
            end
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state     <= IDLE;
            shifter   <= '0;
            hold      <= '0;
            cnt       <= '0;
            hold_full <= 1'b0;
            data_out  <= 2'b00;
            sow       <= 1'b0;
            eow       <= 1'b0;
            busy      <= 1'b0;
        end else if (abort) begin
            // Any word handshaken at this edge is dropped along with the rest.
            state     <= IDLE;
            shifter   <= '0;
            hold      <= '0;
            cnt       <= '0;
            hold_full <= 1'b0;
            data_out  <= 2'b00;
            sow       <= 1'b0;
            eow       <= 1'b0;
            busy      <= 1'b0;
        end else if (load) begin
            state     <= SHIFT;
            shifter   <= load_word;
            cnt       <= '0;
            hold_full <= 1'b0;
            data_out  <= load_word[WIDTH-1:WIDTH-2];
            sow       <= 1'b1;
            eow       <= (NSYM == 1);
            busy      <= 1'b1;
        end else if (state == SHIFT && !last) begin
            shifter  <= shifted;
            cnt      <= cnt + CW'(1);
            data_out <= shifted[WIDTH-1:WIDTH-2];
            sow      <= 1'b0;
            eow      <= ((cnt + CW'(1)) == LAST);
            busy     <= 1'b1;
            if (accept) begin
                hold      <= in_data;
                hold_full <= 1'b1;
            end
        end else begin
            state    <= IDLE;
            shifter  <= '0;
            cnt      <= '0;
            data_out <= 2'b00;
            sow      <= 1'b0;
            eow      <= 1'b0;
            busy     <= 1'b0;
        end
    end

endmodule

// File: tb/tb_dibit_serializer.sv
// Randomized bench for dibit_serializer at WIDTH=8 and WIDTH=2, checked
// against a symbol-queue model of the emitted dibit stream.
module tb_dibit_serializer;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;

    logic [7:0] a_data = '0;
    logic       a_valid = 1'b0;
    logic       a_abort = 1'b0;
    logic       a_ready;
    logic [1:0] a_dout;
    logic       a_sow, a_eow, a_busy, a_state;

    logic [1:0] b_data = '0;
    logic       b_valid = 1'b0;
    logic       b_abort = 1'b0;
    logic       b_ready;
    logic [1:0] b_dout;
    logic       b_sow, b_eow, b_busy, b_state;

    int total = 0;
    int bad = 0;

    // Expected symbols still to appear; head is the one on data_out now.
    // Entry = {sow, eow, dibit}.
    logic [3:0] q8[$];
    logic [3:0] q2[$];

    always #5 clk = ~clk;

    dibit_serializer #(.WIDTH(8)) dut8 (
        .clock(clk), .reset(rst_n), .in_data(a_data), .in_valid(a_valid),
        .in_ready(a_ready), .abort(a_abort), .data_out(a_dout), .sow(a_sow),
        .eow(a_eow), .busy(a_busy), .state_dbg(a_state)
    );

    dibit_serializer #(.WIDTH(2)) dut2 (
        .clock(clk), .reset(rst_n), .in_data(b_data), .in_valid(b_valid),
        .in_ready(b_ready), .abort(b_abort), .data_out(b_dout), .sow(b_sow),
        .eow(b_eow), .busy(b_busy), .state_dbg(b_state)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
        end
    endtask

    // Room for a new word unless a whole word is waiting behind the current one.
    function automatic logic ready8();
        for (int i = 1; i < q8.size(); i++)
            if (q8[i][3]) return 1'b0;
        return 1'b1;
    endfunction

    function automatic logic ready2();
        for (int i = 1; i < q2.size(); i++)
            if (q2[i][3]) return 1'b0;
        return 1'b1;
    endfunction

    task automatic check8();
        logic [3:0] e;
        e = (q8.size() > 0) ? q8[0] : 4'b0000;
        chk("w8_data", 32'(a_dout), 32'(e[1:0]));
        chk("w8_sow", 32'(a_sow), 32'(e[3]));
        chk("w8_eow", 32'(a_eow), 32'(e[2]));
        chk("w8_busy", 32'(a_busy), 32'(q8.size() > 0));
        chk("w8_ready", 32'(a_ready), 32'(ready8()));
    endtask

    task automatic check2();
        logic [3:0] e;
        e = (q2.size() > 0) ? q2[0] : 4'b0000;
        chk("w2_data", 32'(b_dout), 32'(e[1:0]));
        chk("w2_sow", 32'(b_sow), 32'(e[3]));
        chk("w2_eow", 32'(b_eow), 32'(e[2]));
        chk("w2_busy", 32'(b_busy), 32'(q2.size() > 0));
        chk("w2_ready", 32'(b_ready), 32'(ready2()));
    endtask

    // One clock for the WIDTH=8 instance: drive, advance the model, check.
    task automatic cyc8(input logic v, input logic [7:0] d, input logic ab, output logic acc);
        acc = v && ready8();
        a_valid = v;
        a_data  = d;
        a_abort = ab;
        @(posedge clk);
        if (ab) begin
            q8.delete();
        end else begin
            if (q8.size() > 0) void'(q8.pop_front());
            if (acc)
                for (int i = 0; i < 4; i++)
                    q8.push_back({(i == 0), (i == 3), 2'(d >> (2 * (3 - i)))});
        end
        @(negedge clk);
        check8();
    endtask

    task automatic cyc2(input logic v, input logic [1:0] d, input logic ab, output logic acc);
        acc = v && ready2();
        b_valid = v;
        b_data  = d;
        b_abort = ab;
        @(posedge clk);
        if (ab) begin
            q2.delete();
        end else begin
            if (q2.size() > 0) void'(q2.pop_front());
            if (acc) q2.push_back({1'b1, 1'b1, d});
        end
        @(negedge clk);
        check2();
    endtask

    task automatic send8(input logic [7:0] w);
        logic acc = 1'b0;
        int n = 0;
        while (!acc && n < 20) begin
            cyc8(1'b1, w, 1'b0, acc);
            n++;
        end
        if (!acc) chk("w8_accept_timeout", 32'(acc), 32'd1);
    endtask

    task automatic idle8(input int n);
        logic acc;
        for (int i = 0; i < n; i++) cyc8(1'b0, 8'h00, 1'b0, acc);
    endtask

    task automatic idle2(input int n);
        logic acc;
        for (int i = 0; i < n; i++) cyc2(1'b0, 2'b00, 1'b0, acc);
    endtask

    // Reset pulled low between edges; outputs must clear without a clock.
    task automatic async_reset();
        #2;
        rst_n = 1'b0;
        #1;
        chk("rst_w8_data", 32'(a_dout), 32'd0);
        chk("rst_w8_sow", 32'(a_sow), 32'd0);
        chk("rst_w8_eow", 32'(a_eow), 32'd0);
        chk("rst_w8_busy", 32'(a_busy), 32'd0);
        chk("rst_w8_ready", 32'(a_ready), 32'd1);
        chk("rst_w2_data", 32'(b_dout), 32'd0);
        chk("rst_w2_busy", 32'(b_busy), 32'd0);
        q8.delete();
        q2.delete();
        a_valid = 1'b0;
        b_valid = 1'b0;
        a_abort = 1'b0;
        b_abort = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        logic acc;
        repeat (2) @(negedge clk);
        check8();
        check2();
        rst_n = 1'b1;

        // Single word from idle, then drain.
        send8(8'hB4);
        idle8(6);

        // Back-to-back stream with valid held high through backpressure.
        send8(8'hB4);
        send8(8'h1E);
        send8(8'hFF);
        idle8(14);

        // Abort on the second dibit of B4 while 1E sits in the hold register.
        send8(8'hB4);
        send8(8'h1E);
        cyc8(1'b0, 8'h00, 1'b1, acc);
        idle8(6);

        // Abort and accept on the same edge: the word is dropped.
        cyc8(1'b1, 8'hA5, 1'b1, acc);
        idle8(3);

        // Asynchronous reset mid-word, then a fresh word.
        send8(8'hB4);
        idle8(1);
        async_reset();
        send8(8'h6C);
        idle8(6);

        for (int i = 0; i < 400; i++)
            cyc8(($urandom_range(0, 3) != 0), 8'($urandom), ($urandom_range(0, 24) == 0), acc);
        idle8(10);

        // WIDTH=2: each word is a single cycle with sow and eow together.
        cyc2(1'b1, 2'b11, 1'b0, acc);
        cyc2(1'b1, 2'b01, 1'b0, acc);
        cyc2(1'b1, 2'b10, 1'b0, acc);
        idle2(3);
        for (int i = 0; i < 200; i++)
            cyc2(($urandom_range(0, 2) != 0), 2'($urandom), ($urandom_range(0, 15) == 0), acc);
        async_reset();
        idle2(2);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
